// File: rtl/pairing_pkg.sv
// Shared constants and state encoding for the Tate-pairing host interface.
package pairing_pkg;

    localparam int M        = 97;
    localparam int OP_BITS  = 2 * M;
    localparam int RES_BITS = 12 * M;
    localparam int DEFAULT_WORD_W = 32;

    function automatic int words_for(input int bits, input int word_w);
        return (bits + word_w - 1) / word_w;
    endfunction

    localparam int OP_WORDS  = words_for(OP_BITS, DEFAULT_WORD_W);
    localparam int RES_WORDS = words_for(RES_BITS, DEFAULT_WORD_W);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        UNLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/f3_trit_check.sv
// Combinational detector for the illegal GF(3) trit encoding 2'b11 among the
// masked (in-range) bit pairs of one host word.
module f3_trit_check #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic [W-1:0] mask,
    output logic         illegal
);

    logic [W/2-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < W / 2; i++) begin
            hit[i] = data[2*i] & data[2*i+1] & mask[2*i] & mask[2*i+1];
        end
    end

    assign illegal = |hit;

endmodule

// File: rtl/pairing_host_if.sv
// Host word-stream wrapper around a tate_pairing core: load four operands,
// release the core, then stream the result back. Optional PAIRING_TRIT_CHECK_EN.
module pairing_host_if
    import pairing_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    output logic                core_reset,
    output logic [OP_BITS-1:0]  core_x1,
    output logic [OP_BITS-1:0]  core_y1,
    output logic [OP_BITS-1:0]  core_x2,
    output logic [OP_BITS-1:0]  core_y2,
    input  logic                core_done,
    input  logic [RES_BITS-1:0] core_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_last,
    output logic                busy,
    output logic                err
);

    localparam int N_OP_WORDS  = words_for(OP_BITS, WORD_W);
    localparam int N_LOAD      = 4 * N_OP_WORDS;
    localparam int N_RES_WORDS = words_for(RES_BITS, WORD_W);
    localparam int OP_SPAN     = N_OP_WORDS * WORD_W;
    localparam int LOAD_SPAN   = N_LOAD * WORD_W;
    localparam int RES_SPAN    = N_RES_WORDS * WORD_W;
    localparam int LCNT_W      = $clog2(N_LOAD + 1);
    localparam int RCNT_W      = $clog2(N_RES_WORDS + 1);

    state_t state, state_next;

    logic [LCNT_W-1:0]    load_cnt;
    logic [RCNT_W-1:0]    res_cnt;
    logic [LOAD_SPAN-1:0] load_sr;
    logic [RES_SPAN-1:0]  res_buf;
    logic                 in_fire;
    logic                 out_fire;
    logic                 load_done;
    logic                 trit_bad;
    logic                 unused_bits;

    assign in_fire   = in_valid & (state == LOAD);
    assign out_fire  = out_ready & (state == UNLOAD);
    assign load_done = in_fire & ~trit_bad & (load_cnt == LCNT_W'(N_LOAD - 1));
    assign out_last  = (state == UNLOAD) && (res_cnt == RCNT_W'(N_RES_WORDS - 1));
    assign out_data  = res_buf[WORD_W-1:0];

    // Words shift in from the top, so after a full load operand k sits at k*OP_SPAN.
    assign core_x1 = load_sr[0*OP_SPAN +: OP_BITS];
    assign core_y1 = load_sr[1*OP_SPAN +: OP_BITS];
    assign core_x2 = load_sr[2*OP_SPAN +: OP_BITS];
    assign core_y2 = load_sr[3*OP_SPAN +: OP_BITS];
    assign unused_bits = ^load_sr;

`ifdef PAIRING_TRIT_CHECK_EN
    localparam int LAST_BITS = OP_BITS - (N_OP_WORDS - 1) * WORD_W;
    localparam logic [WORD_W-1:0] LAST_MASK = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);

    logic [WORD_W-1:0] trit_mask;
    logic              err_q;

    assign trit_mask = ((int'(load_cnt) % N_OP_WORDS) == N_OP_WORDS - 1) ? LAST_MASK : '1;

    f3_trit_check #(.W(WORD_W)) u_trit_check (
        .data    (in_data),
        .mask    (trit_mask),
        .illegal (trit_bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (in_fire && trit_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign trit_bad = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_reset = 1'b0;
        busy       = 1'b0;
        case (state)
            LOAD: begin
                in_ready   = 1'b1;
                core_reset = 1'b1;
                if (load_done) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (core_done) state_next = UNLOAD;
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && out_last) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // A rejected word restarts the load from x1 word 0 without shifting it in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt <= '0;
            res_cnt  <= '0;
            load_sr  <= '0;
            res_buf  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (trit_bad) begin
                            load_cnt <= '0;
                        end else begin
                            load_sr  <= {in_data, load_sr[LOAD_SPAN-1:WORD_W]};
                            load_cnt <= load_done ? '0 : load_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        res_buf <= RES_SPAN'(core_out);
                        res_cnt <= '0;
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        if (out_last) begin
                            res_cnt <= '0;
                            res_buf <= '0;
                            load_sr <= '0;
                        end else begin
                            res_cnt <= res_cnt + 1'b1;
                            res_buf <= res_buf >> WORD_W;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
